// File: rtl/ps2_key_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_key_sequencer
//
// Turns the raw Set-2 byte stream from the PS/2 receiver into single key
// events. The E0 (extended), F0 (break) and E1 (pause) prefixes are folded
// into flags on one event. Events are queued in a small FIFO that the
// consumer drains through a valid/ready handshake. Frame errors, stalled
// sequences and keyboard responses (ACK, BAT, echo, resend, ...) never
// produce events. Frame errors and stalled sequences are counted.
//
// Parameters
//   FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  max i_clk cycles between bytes of one sequence
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_byte       received scan byte, qualified by i_byte_vld
//   i_byte_vld   one-cycle strobe per received byte
//   i_frame_err  parity/stop error on the strobed byte
//   o_evt_code   FIFO head: final scan code (0 when empty)
//   o_evt_ext    FIFO head: extended key (E0 or E1 sequence)
//   o_evt_brk    FIFO head: key release
//   o_evt_vld    FIFO not empty
//   i_evt_rdy    consumer takes the head while o_evt_vld=1
//   o_overflow   sticky: an event was dropped on a full FIFO
//   o_err_cnt    saturating count of frame errors plus timeouts
// -----------------------------------------------------------------------------
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_vld,
  input  logic       i_frame_err,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_brk,
  output logic       o_evt_vld,
  input  logic       i_evt_rdy,
  output logic       o_overflow,
  output logic [7:0] o_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] gap_cnt_q;
  logic          frame_err, timeout;
  logic          push;
  evt_t          push_evt;

  assign frame_err = i_byte_vld & i_frame_err;
  // A timeout needs a quiet cycle, so it can never coincide with a frame
  // error; the error counter sees at most one increment per edge.
  assign timeout   = (state_q != S_IDLE) && !i_byte_vld &&
                     (gap_cnt_q == TW'(TIMEOUT_CYC - 1));

  // ---------------------------------------------------------------------------
  // Sequence decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_evt = '0;

    if (frame_err || timeout) begin
      state_d = S_IDLE;
      skip_d  = '0;
    end else if (i_byte_vld) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (i_byte)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            // Device responses and buffer-overrun codes: dropped silently.
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
              push     = 1'b1;
              push_evt = '{code: i_byte, ext: 1'b0, brk: 1'b0};
            end
          endcase
        end
        S_EXT: begin
          if (i_byte == 8'hF0) begin
            state_d = S_EXTBRK;
          end else begin
            push     = 1'b1;
            push_evt = '{code: i_byte, ext: 1'b1, brk: 1'b0};
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          push     = 1'b1;
          push_evt = '{code: i_byte, ext: 1'b0, brk: 1'b1};
          state_d  = S_IDLE;
        end
        S_EXTBRK: begin
          push     = 1'b1;
          push_evt = '{code: i_byte, ext: 1'b1, brk: 1'b1};
          state_d  = S_IDLE;
        end
        S_PAUSE: begin
          // Pause has no break code; its 7 trailing bytes are fixed and
          // collapse into a single extended make of 0x77.
          if (skip_q == 3'd1) begin
            push     = 1'b1;
            push_evt = '{code: 8'h77, ext: 1'b1, brk: 1'b0};
            state_d  = S_IDLE;
            skip_d   = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          skip_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    if (i_rst) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Inter-byte gap counter: held at zero in IDLE, restarted by every byte.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_byte_vld || timeout || state_q == S_IDLE) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_cnt <= '0;
    end else if ((frame_err || timeout) && o_err_cnt != 8'hFF) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  evt_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_ok;
  evt_t        head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && i_evt_rdy;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) o_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are live, and the outputs are masked while empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_evt;
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign o_evt_vld  = !empty;
  assign o_evt_code = empty ? 8'h00 : head.code;
  assign o_evt_ext  = empty ? 1'b0  : head.ext;
  assign o_evt_brk  = empty ? 1'b0  : head.brk;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_sequencer
//
// Self-checking bench for ps2_key_sequencer. Table-driven byte vectors plus
// hand-written sequences for overflow, timeout, frame errors and reset.
// Expected events go into a scoreboard queue when the completing byte is
// driven; a monitor pops and compares whenever the DUT hands an event over.
// -----------------------------------------------------------------------------
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 40;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  typedef struct {
    logic [7:0] b;
    logic       ferr;
    logic       has_evt;
    evt_t       evt;
  } vec_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_vld = 1'b0;
  logic       i_frame_err = 1'b0;
  logic       i_evt_rdy = 1'b0;
  logic [7:0] o_evt_code;
  logic       o_evt_ext;
  logic       o_evt_brk;
  logic       o_evt_vld;
  logic       o_overflow;
  logic [7:0] o_err_cnt;

  int   checks = 0;
  int   failures = 0;
  evt_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_byte     (i_byte),
    .i_byte_vld (i_byte_vld),
    .i_frame_err(i_frame_err),
    .o_evt_code (o_evt_code),
    .o_evt_ext  (o_evt_ext),
    .o_evt_brk  (o_evt_brk),
    .o_evt_vld  (o_evt_vld),
    .i_evt_rdy  (i_evt_rdy),
    .o_overflow (o_overflow),
    .o_err_cnt  (o_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an event is consumed on the edge after a cycle with vld & rdy.
  always @(negedge clk) begin
    #1;
    if (!i_rst && o_evt_vld && i_evt_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got=%0h expected=none",
                 {o_evt_code, o_evt_ext, o_evt_brk});
      end else begin
        evt_t exp_evt;
        exp_evt = sb.pop_front();
        check("event", 32'({o_evt_code, o_evt_ext, o_evt_brk}), 32'(exp_evt));
      end
    end
  end

  task automatic put(input logic [7:0] b, input logic fe);
    @(negedge clk);
    i_byte      = b;
    i_byte_vld  = 1'b1;
    i_frame_err = fe;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_byte_vld  = 1'b0;
      i_frame_err = 1'b0;
    end
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
    sb.push_back('{code: code, ext: ext, brk: brk});
  endtask

  task automatic reset_dut();
    idle(1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    sb.delete();
  endtask

  // Let the consumer run until every expected event has been seen.
  task automatic drain(input int budget);
    int n = 0;
    i_evt_rdy = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got=%0d pending expected=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    #1;
    check("fifo_empty_after_drain", 32'(o_evt_vld), 32'd0);
  endtask

  function automatic vec_t v(input logic [7:0] b, input logic has,
                             input logic [7:0] code, input logic ext, input logic brk);
    vec_t r;
    r.b       = b;
    r.ferr    = 1'b0;
    r.has_evt = has;
    r.evt     = '{code: code, ext: ext, brk: brk};
    return r;
  endfunction

  initial begin
    // Make/break, extended, device responses, pause (twice), BRK + E0.
    vecs.push_back(v(8'h1C, 1, 8'h1C, 0, 0));
    vecs.push_back(v(8'hF0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h1C, 1, 8'h1C, 0, 1));
    vecs.push_back(v(8'hE0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h75, 1, 8'h75, 1, 0));
    vecs.push_back(v(8'hE0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hF0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h75, 1, 8'h75, 1, 1));
    vecs.push_back(v(8'hFA, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hAA, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hEE, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hFE, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hFF, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hE1, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h14, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h77, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hE1, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hF0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h14, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hF0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h77, 1, 8'h77, 1, 0));
    vecs.push_back(v(8'hE1, 0, 8'h00, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(v(8'hE0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'h12, 1, 8'h77, 1, 0));
    vecs.push_back(v(8'h5A, 1, 8'h5A, 0, 0));
    vecs.push_back(v(8'hF0, 0, 8'h00, 0, 0));
    vecs.push_back(v(8'hE0, 1, 8'hE0, 0, 1));

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    #1;
    check("rst_vld",  32'(o_evt_vld),  32'd0);
    check("rst_code", 32'(o_evt_code), 32'd0);
    check("rst_ext",  32'(o_evt_ext),  32'd0);
    check("rst_brk",  32'(o_evt_brk),  32'd0);
    check("rst_ovf",  32'(o_overflow), 32'd0);
    check("rst_err",  32'(o_err_cnt),  32'd0);

    // ---- Table: back-to-back strobes, consumer always ready ----
    i_evt_rdy = 1'b1;
    foreach (vecs[i]) begin
      put(vecs[i].b, vecs[i].ferr);
      if (vecs[i].has_evt) sb.push_back(vecs[i].evt);
    end
    idle(1);
    drain(20);
    check("table_err_cnt", 32'(o_err_cnt), 32'd0);

    // ---- Overflow: five pushes into a four-entry FIFO ----
    reset_dut();
    i_evt_rdy = 1'b0;
    put(8'h15, 1'b0);
    put(8'h16, 1'b0);
    #1;
    check("latency_vld",  32'(o_evt_vld),  32'd1);
    check("latency_code", 32'(o_evt_code), 32'h15);
    put(8'h1E, 1'b0);
    put(8'h26, 1'b0);
    put(8'h25, 1'b0);
    idle(3);
    #1;
    check("overflow_set", 32'(o_overflow), 32'd1);
    check("stall_head",   32'(o_evt_code), 32'h15);
    expect_evt(8'h15, 0, 0);
    expect_evt(8'h16, 0, 0);
    expect_evt(8'h1E, 0, 0);
    expect_evt(8'h26, 0, 0);
    drain(10);

    // ---- Full FIFO with pop and push on the same edge ----
    reset_dut();
    i_evt_rdy = 1'b0;
    put(8'h15, 1'b0);
    put(8'h16, 1'b0);
    put(8'h1E, 1'b0);
    put(8'h26, 1'b0);
    expect_evt(8'h15, 0, 0);
    expect_evt(8'h16, 0, 0);
    expect_evt(8'h1E, 0, 0);
    expect_evt(8'h26, 0, 0);
    expect_evt(8'h25, 0, 0);
    put(8'h25, 1'b0);
    i_evt_rdy = 1'b1;
    idle(1);
    drain(10);
    check("no_overflow", 32'(o_overflow), 32'd0);

    // ---- Timeout: one cycle short of the limit, then exactly at it ----
    reset_dut();
    i_evt_rdy = 1'b1;
    put(8'hE0, 1'b0);
    idle(TO - 1);
    put(8'h75, 1'b0);
    expect_evt(8'h75, 1, 0);
    idle(1);
    #1;
    check("no_timeout_err", 32'(o_err_cnt), 32'd0);
    drain(5);
    put(8'hE0, 1'b0);
    idle(TO);
    put(8'h1C, 1'b0);
    expect_evt(8'h1C, 0, 0);
    idle(1);
    #1;
    check("timeout_err", 32'(o_err_cnt), 32'd1);
    drain(5);

    // ---- Frame errors abort BRK and PAUSE sequences ----
    put(8'hF0, 1'b0);
    put(8'h1C, 1'b1);
    put(8'h1C, 1'b0);
    expect_evt(8'h1C, 0, 0);
    idle(1);
    #1;
    check("frame_err_cnt", 32'(o_err_cnt), 32'd2);
    put(8'hE1, 1'b0);
    put(8'h14, 1'b0);
    put(8'h77, 1'b1);
    put(8'h1C, 1'b0);
    expect_evt(8'h1C, 0, 0);
    idle(1);
    #1;
    check("pause_abort_err", 32'(o_err_cnt), 32'd3);
    drain(5);

    // ---- Error counter saturation ----
    for (int i = 0; i < 260; i++) put(8'h1C, 1'b1);
    idle(1);
    #1;
    check("err_saturate", 32'(o_err_cnt), 32'd255);
    check("err_no_event", 32'(o_evt_vld), 32'd0);

    // ---- Reset with queued events and EXTBRK in progress ----
    i_evt_rdy = 1'b0;
    put(8'h1C, 1'b0);
    put(8'h1D, 1'b0);
    put(8'hE0, 1'b0);
    put(8'hF0, 1'b0);
    idle(1);
    i_rst = 1'b1;
    sb.delete();
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    check("midrst_vld",  32'(o_evt_vld),  32'd0);
    check("midrst_code", 32'(o_evt_code), 32'd0);
    check("midrst_ext",  32'(o_evt_ext),  32'd0);
    check("midrst_brk",  32'(o_evt_brk),  32'd0);
    check("midrst_ovf",  32'(o_overflow), 32'd0);
    check("midrst_err",  32'(o_err_cnt),  32'd0);
    i_evt_rdy = 1'b1;
    put(8'h1C, 1'b0);
    expect_evt(8'h1C, 0, 0);
    idle(1);
    drain(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Scan-code sequencer between the PS/2 byte receiver and keyboard consumers (display, UART echo, LED logic). Consumes the receiver's byte strobe and assembles Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events. Events are buffered in a small FIFO behind a valid/ready handshake. Protocol noise is counted and discarded: frame errors, stalled sequences and device responses.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- TIMEOUT_CYC, 50000, max i_clk cycles between bytes of one sequence before it is abandoned
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_byte  in  8  received scan byte, valid only with i_byte_vld
- i_byte_vld  in  1  one-cycle strobe per received byte
- i_frame_err  in  1  qualified by i_byte_vld; parity/stop error on this byte
- o_evt_code  out  8  FIFO head: final scan code
- o_evt_ext  out  1  FIFO head: extended key (E0 or E1 sequence)
- o_evt_brk  out  1  FIFO head: key release
- o_evt_vld  out  1  FIFO not empty
- i_evt_rdy  in  1  consumer accepts the head when o_evt_vld=1
- o_overflow  out  1  sticky; an event was dropped because the FIFO was full
- o_err_cnt  out  8  saturating count of frame errors plus timeouts

## Operation
- States:
  - IDLE: no sequence in progress.
  - EXT: E0 received.
  - BRK: F0 received.
  - EXTBRK: E0 F0 received.
  - PAUSE: E1 received; 7 more bytes to skip.
- IDLE transitions:
  - E0 → EXT. F0 → BRK. E1 → PAUSE, skip counter loaded with 7.
  - FA, AA, EE, FE, 00, FF → discarded, stay IDLE, no count.
  - Any other byte → push {code, ext=0, brk=0}.
- EXT: F0 → EXTBRK. Any other byte → push {code, ext=1, brk=0}, go to IDLE.
- BRK: any byte → push {code, ext=0, brk=1}, go to IDLE.
- EXTBRK: any byte → push {code, ext=1, brk=1}, go to IDLE.
- PAUSE:
  - Each byte decrements the skip counter; byte contents are ignored.
  - On the 7th byte → push {0x77, ext=1, brk=0}, go to IDLE.
- Frame error (i_byte_vld & i_frame_err) in any state:
  - Byte discarded, state → IDLE, skip counter cleared.
  - o_err_cnt increments, saturating at 255.
- Timeout:
  - Inter-byte counter runs only in non-IDLE states and clears on every i_byte_vld.
  - Reaching TIMEOUT_CYC → state IDLE, o_err_cnt +1, no event pushed.
  - Timeout and frame error on the same cycle count once.
- FIFO:
  - Push is ignored when the FIFO is full and no pop occurs that cycle; o_overflow is set.
  - Full with a simultaneous pop and push: push accepted, no overflow.
  - Order preserved; pointers wrap modulo FIFO_DEPTH.
  - Pop when o_evt_vld & i_evt_rdy.
- Reset (including mid-sequence or with a non-empty FIFO): state IDLE, FIFO empty, counters 0.
- Reset values: o_evt_vld=0, o_evt_code=0, o_evt_ext=0, o_evt_brk=0, o_overflow=0, o_err_cnt=0.

## Timing
- Byte strobe sampled at edge N. A completing byte is written to the FIFO at edge N.
- With an empty FIFO, o_evt_vld=1 and the event fields are valid in the cycle after edge N; latency is 1 cycle.
- Event outputs are stable while o_evt_vld=1 and i_evt_rdy=0.
- Pop at edge M: the next entry (if any) is presented in the cycle after edge M. Back-to-back pops sustain 1 event/cycle.
- Push and pop in the same cycle with the FIFO non-empty: occupancy unchanged.
- Timeout fires on the edge where the inter-byte counter equals TIMEOUT_CYC−1 with no i_byte_vld.
- i_byte_vld is never required to be held; strobes may arrive on consecutive cycles, and each is processed.
- i_rst overrides every other input on the same edge.

## Test plan
- Make/break:
  - Stimulus: bytes 1C, then F0 1C; i_evt_rdy=1.
  - Response: events {1C,0,0} then {1C,0,1}; o_err_cnt=0.
- Extended keys:
  - Stimulus: E0 75, then E0 F0 75.
  - Response: {75,1,0} then {75,1,1}.
  - Stimulus: FA, AA.
  - Response: no event.
- Pause:
  - Stimulus: E1 14 77 E1 F0 14 F0 77.
  - Response: exactly one event {77,1,0}, issued after the 8th byte.
- Overflow:
  - Stimulus: i_evt_rdy=0; 5 make codes 15 16 1E 26 25.
  - Response: o_overflow=1. Draining yields 15 16 1E 26 in order, then o_evt_vld=0.
  - Stimulus: repeat with a pop on the 5th push cycle.
  - Response: no overflow.
- Timeout and errors:
  - Stimulus: E0, then idle TIMEOUT_CYC cycles, then 1C.
  - Response: o_err_cnt=1, event {1C,0,0}.
  - Stimulus: F0 followed by 1C with i_frame_err=1, then 1C.
  - Response: o_err_cnt=2, event {1C,0,0}.
- Reset mid-operation:
  - Stimulus: 2 events queued and state EXTBRK; pulse i_rst 1 cycle; then 1C.
  - Response: all outputs 0 after the reset edge; then single event {1C,0,0}.
